// File: rtl/operand_collector.sv
// ---------------------------------------------------------------------------
// operand_collector
//
// Purpose:
//   Accepts one issued instruction at a time and reads up to three source
//   operands from a shared register bank through an arbitrated read port.
//   The operands are gathered into a bundle, which is held at the output
//   until downstream accepts it.
//   Reads go out in ascending source order and skip sources whose mask bit
//   is clear. Read data returns one cycle after the read is issued. That
//   data is captured while the next read is being issued, so an unbroken
//   grant yields one operand per cycle.
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   in_valid     instruction offered
//   in_ready     instruction accepted this cycle (IDLE only)
//   in_rs1_addr  source 1 register address
//   in_rs2_addr  source 2 register address
//   in_rs3_addr  source 3 register address
//   in_rs_mask   bit k set means source k+1 is needed
//   in_tag       opaque tag, passed through to out_tag
//   rf_req       read request to the bank arbiter
//   rf_gnt       arbiter grant (can drop in any cycle)
//   rf_en        bank read enable = rf_req & rf_gnt
//   rf_addr      bank read address
//   rf_data      bank read data, valid the cycle after rf_en
//   out_valid    operand bundle available
//   out_ready    downstream accepts the bundle
//   out_op1      collected operand for source 1 (0 if not needed)
//   out_op2      collected operand for source 2 (0 if not needed)
//   out_op3      collected operand for source 3 (0 if not needed)
//   out_tag      tag of the instruction in the bundle
// ---------------------------------------------------------------------------
module operand_collector #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1_addr,
   input  logic [ADDR_W-1:0] in_rs2_addr,
   input  logic [ADDR_W-1:0] in_rs3_addr,
   input  logic [2:0]        in_rs_mask,
   input  logic [7:0]        in_tag,
   output logic              rf_req,
   input  logic              rf_gnt,
   output logic              rf_en,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [DATA_W-1:0] out_op3,
   output logic [7:0]        out_tag
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RD    = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        r_ptr;
   logic [1:0]        r_capIdx;
   logic              r_capPend;
   logic [2:0]        r_mask;
   logic [7:0]        r_tag;
   logic [ADDR_W-1:0] r_rs1Addr;
   logic [ADDR_W-1:0] r_rs2Addr;
   logic [ADDR_W-1:0] r_rs3Addr;
   logic [DATA_W-1:0] r_op1;
   logic [DATA_W-1:0] r_op2;
   logic [DATA_W-1:0] r_op3;

   logic [1:0]        w_firstPtr;
   logic [1:0]        w_nextPtr;
   logic              w_hasNext;

   // Lowest set bit of the incoming mask. This value is used only when the
   // mask is non-zero, so the fall-through case stands for source 3.
   always_comb begin
      w_firstPtr = 2'd2;
      if (in_rs_mask[0]) begin
         w_firstPtr = 2'd0;
      end else if (in_rs_mask[1]) begin
         w_firstPtr = 2'd1;
      end
   end

   // Next higher set mask bit above the current pointer. If there is none,
   // the read just issued was the last one and the next state is DRAIN.
   always_comb begin
      w_hasNext = 1'b0;
      w_nextPtr = r_ptr;
      case (r_ptr)
         2'd0: begin
            if (r_mask[1]) begin
               w_hasNext = 1'b1;
               w_nextPtr = 2'd1;
            end else if (r_mask[2]) begin
               w_hasNext = 1'b1;
               w_nextPtr = 2'd2;
            end
         end
         2'd1: begin
            if (r_mask[2]) begin
               w_hasNext = 1'b1;
               w_nextPtr = 2'd2;
            end
         end
         default: begin
            w_hasNext = 1'b0;
         end
      endcase
   end

   // The handshake outputs are gated by reset. This keeps them quiet during
   // a reset cycle, even when the state register still holds RD or OUT from
   // before the reset.
   assign in_ready  = !reset && (r_state == S_IDLE);
   assign rf_req    = !reset && (r_state == S_RD);
   assign rf_en     = rf_req && rf_gnt;
   assign out_valid = !reset && (r_state == S_OUT);

   always_comb begin
      case (r_ptr)
         2'd0:    rf_addr = r_rs1Addr;
         2'd1:    rf_addr = r_rs2Addr;
         default: rf_addr = r_rs3Addr;
      endcase
   end

   assign out_op1 = r_op1;
   assign out_op2 = r_op2;
   assign out_op3 = r_op3;
   assign out_tag = r_tag;

   // The capture of the previous read's data is independent of the state
   // update, so a capture and a new issue can happen in the same cycle.
   // In IDLE no capture is ever pending, so clearing the operands on accept
   // cannot collide with a capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_capIdx  <= 2'd0;
         r_capPend <= 1'b0;
         r_mask    <= 3'd0;
         r_tag     <= 8'd0;
         r_rs1Addr <= '0;
         r_rs2Addr <= '0;
         r_rs3Addr <= '0;
         r_op1     <= '0;
         r_op2     <= '0;
         r_op3     <= '0;
      end else begin
         r_capPend <= 1'b0;
         if (r_capPend) begin
            case (r_capIdx)
               2'd0:    r_op1 <= rf_data;
               2'd1:    r_op2 <= rf_data;
               default: r_op3 <= rf_data;
            endcase
         end
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_rs1Addr <= in_rs1_addr;
                  r_rs2Addr <= in_rs2_addr;
                  r_rs3Addr <= in_rs3_addr;
                  r_mask    <= in_rs_mask;
                  r_tag     <= in_tag;
                  r_op1     <= '0;
                  r_op2     <= '0;
                  r_op3     <= '0;
                  r_ptr     <= w_firstPtr;
                  r_state   <= (in_rs_mask == 3'd0) ? S_OUT : S_RD;
               end
            end
            S_RD: begin
               if (rf_en) begin
                  r_capPend <= 1'b1;
                  r_capIdx  <= r_ptr;
                  if (w_hasNext) begin
                     r_ptr <= w_nextPtr;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               r_state <= S_OUT;
            end
            default: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
